// File: rtl/sreg_pkg.sv
// Shared helpers for the sample packer path: counter width and lane mapping.
package sreg_pkg;

    function automatic int fill_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

    // Lane written by the sample arriving at a given fill count.
    function automatic int lane_idx(input int fill, input bit lsb_first, input int ratio);
        return lsb_first ? fill : (ratio - 1 - fill);
    endfunction

endpackage

// File: rtl/sreg_hold_reg.sv
// Single-entry valid/ready holding register; a word offered while full and not
// draining is dropped and flagged in a sticky overflow bit.
module sreg_hold_reg #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sclr,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_partial,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_partial,
    output logic          overflow
);

    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          partial_q, partial_d;
    logic          ovf_q, ovf_d;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        partial_d = partial_q;
        ovf_d     = ovf_q;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        // Drain and load may happen together, so a full register still accepts when out_ready=1.
        if (in_valid) begin
            if (!valid_q || out_ready) begin
                data_d    = in_data;
                valid_d   = 1'b1;
                partial_d = in_partial;
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (sclr) begin
            data_d    = '0;
            valid_d   = 1'b0;
            partial_d = 1'b0;
            ovf_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            partial_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            partial_q <= partial_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign out_partial = partial_q;
    assign overflow    = ovf_q;

endmodule

// File: rtl/sreg_word_packer.sv
// Packs RATIO strobed WIDTH-bit samples into one wide word and hands it to a
// single-entry valid/ready holding register; flush emits a zero-padded partial word.
module sreg_word_packer
    import sreg_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int RATIO     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                sclr,
    input  logic                                in_valid,
    input  logic [WIDTH-1:0]                    d,
    input  logic                                flush,
    output logic [RATIO*WIDTH-1:0]              out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_partial,
    output logic [fill_width(RATIO)-1:0]        fill,
    output logic                                overflow
);

    localparam int FW = fill_width(RATIO);
    localparam int DW = RATIO * WIDTH;

    logic [DW-1:0] acc_q, acc_d, acc_next;
    logic [FW-1:0] fill_q, fill_d, cnt_next;
    logic          full;
    logic          offer;
    logic          offer_partial;
    int            lane;

    always_comb begin
        lane     = lane_idx(int'(fill_q), LSB_FIRST, RATIO);
        acc_next = acc_q;
        for (int i = 0; i < RATIO; i++) begin
            if (in_valid && (i == lane)) begin
                acc_next[i*WIDTH +: WIDTH] = d;
            end
        end

        cnt_next      = fill_q + FW'(in_valid);
        full          = in_valid && (fill_q == FW'(RATIO - 1));
        offer         = full || (flush && (cnt_next != '0));
        offer_partial = offer && !full;

        // Clearing the accumulator on every offer keeps stale lanes out of later partial words.
        acc_d  = offer ? '0 : acc_next;
        fill_d = offer ? '0 : cnt_next;

        if (sclr) begin
            acc_d         = '0;
            fill_d        = '0;
            offer         = 1'b0;
            offer_partial = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            fill_q <= '0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
        end
    end

    assign fill = fill_q;

    sreg_hold_reg #(
        .DW (DW)
    ) u_hold (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclr        (sclr),
        .in_valid    (offer),
        .in_data     (acc_next),
        .in_partial  (offer_partial),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_partial (out_partial),
        .overflow    (overflow)
    );

endmodule

// File: tb/tb_sreg_word_packer.sv
// Scoreboard bench for sreg_word_packer: LSB-first and MSB-first instances share stimulus.
module tb_sreg_word_packer;

    localparam int RATIO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclr = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  d = 4'h0;

    logic [15:0] out_data, out_data_m;
    logic        out_valid, out_valid_m;
    logic        out_partial, out_partial_m;
    logic        overflow, overflow_m;
    logic [2:0]  fill, fill_m;

    always #5 clk = ~clk;

    sreg_word_packer #(.WIDTH(4), .RATIO(4), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .sclr(sclr), .in_valid(in_valid), .d(d), .flush(flush),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_partial(out_partial), .fill(fill), .overflow(overflow)
    );

    sreg_word_packer #(.WIDTH(4), .RATIO(4), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .sclr(sclr), .in_valid(in_valid), .d(d), .flush(flush),
        .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready),
        .out_partial(out_partial_m), .fill(fill_m), .overflow(overflow_m)
    );

    typedef struct {
        logic [15:0] data;
        logic [15:0] mdata;
        logic        partial;
    } word_t;

    word_t sb[$];
    int    smp[$];
    logic  m_valid = 1'b0;
    logic  m_ov = 1'b0;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        smp.delete();
        m_valid = 1'b0;
        m_ov    = 1'b0;
    endtask

    task automatic check_outputs();
        chk("valid",   32'(out_valid),   32'(m_valid));
        chk("valid_m", 32'(out_valid_m), 32'(m_valid));
        chk("fill",    32'(fill),        32'(smp.size()));
        chk("fill_m",  32'(fill_m),      32'(smp.size()));
        chk("ovf",     32'(overflow),    32'(m_ov));
        chk("ovf_m",   32'(overflow_m),  32'(m_ov));
        if (m_valid && sb.size() > 0) begin
            chk("data",      32'(out_data),      32'(sb[0].data));
            chk("data_m",    32'(out_data_m),    32'(sb[0].mdata));
            chk("partial",   32'(out_partial),   32'(sb[0].partial));
            chk("partial_m", 32'(out_partial_m), 32'(sb[0].partial));
        end
    endtask

    // Inputs are applied just after a falling edge; outputs are checked on the next falling edge.
    task automatic step(input logic iv, input logic [3:0] dv, input logic fl,
                        input logic rdy, input logic sc);
        word_t w;
        logic  offer;
        in_valid  = iv;
        d         = dv;
        flush     = fl;
        out_ready = rdy;
        sclr      = sc;
        if (sc) begin
            model_reset();
        end else begin
            if (m_valid && rdy) begin
                w = sb.pop_front();
                m_valid = 1'b0;
            end
            if (iv) smp.push_back(int'(dv));
            offer = (smp.size() == RATIO) || (fl && smp.size() > 0);
            if (offer) begin
                w.data    = 16'h0;
                w.mdata   = 16'h0;
                w.partial = (smp.size() < RATIO);
                for (int i = 0; i < smp.size(); i++) begin
                    w.data  = w.data  | (16'(smp[i]) << (4 * i));
                    w.mdata = w.mdata | (16'(smp[i]) << (4 * (RATIO - 1 - i)));
                end
                smp.delete();
                if (!m_valid) begin
                    sb.push_back(w);
                    m_valid = 1'b1;
                end else begin
                    m_ov = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        in_valid = 1'b0;
        flush    = 1'b0;
        sclr     = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data",  32'(out_data),  32'h0);
        chk("rst_fill",  32'(fill),      32'h0);
        chk("rst_ovf",   32'(overflow),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic packing, both lane orders
        step(1, 4'h1, 0, 1, 0);
        step(1, 4'h2, 0, 1, 0);
        step(1, 4'h3, 0, 1, 0);
        step(1, 4'h4, 0, 1, 0);
        chk("basic_lsb",     32'(out_data),    32'h4321);
        chk("basic_msb",     32'(out_data_m),  32'h1234);
        chk("basic_partial", 32'(out_partial), 32'h0);
        chk("basic_fill",    32'(fill),        32'h0);
        step(0, 4'h0, 0, 1, 0);

        // Gapped input
        step(1, 4'hA, 0, 1, 0); chk("gap_fill1", 32'(fill), 32'd1);
        step(0, 4'h0, 0, 1, 0); chk("gap_fill2", 32'(fill), 32'd1);
        step(0, 4'h0, 0, 1, 0); chk("gap_fill3", 32'(fill), 32'd1);
        step(1, 4'hB, 0, 1, 0); chk("gap_fill4", 32'(fill), 32'd2);
        step(1, 4'hC, 0, 1, 0); chk("gap_fill5", 32'(fill), 32'd3);
        step(0, 4'h0, 0, 1, 0); chk("gap_fill6", 32'(fill), 32'd3);
        step(1, 4'hD, 0, 1, 0); chk("gap_fill7", 32'(fill), 32'd0);
        chk("gap_data", 32'(out_data), 32'hDCBA);
        step(0, 4'h0, 0, 1, 0);

        // Backpressure and overflow
        for (int i = 1; i <= 8; i++) step(1, 4'(i), 0, 0, 0);
        chk("bp_ovf",  32'(overflow),  32'h1);
        chk("bp_data", 32'(out_data),  32'h4321);
        chk("bp_vld",  32'(out_valid), 32'h1);
        step(0, 4'h0, 0, 0, 1);
        chk("sclr_ovf",  32'(overflow),  32'h0);
        chk("sclr_vld",  32'(out_valid), 32'h0);
        chk("sclr_data", 32'(out_data),  32'h0);

        // Simultaneous drain and load
        step(1, 4'h9, 0, 0, 0);
        step(1, 4'hA, 0, 0, 0);
        step(1, 4'hB, 0, 0, 0);
        step(1, 4'hC, 0, 0, 0);
        step(1, 4'hD, 0, 0, 0);
        step(1, 4'hE, 0, 0, 0);
        step(1, 4'hF, 0, 0, 0);
        chk("sim_hold", 32'(out_data), 32'hCBA9);
        step(1, 4'h1, 0, 1, 0);
        chk("sim_vld",  32'(out_valid), 32'h1);
        chk("sim_data", 32'(out_data),  32'h1FED);
        chk("sim_ovf",  32'(overflow),  32'h0);
        step(0, 4'h0, 0, 1, 0);

        // Flush: partial, empty, and with a final sample
        step(1, 4'h5, 0, 1, 0);
        step(1, 4'h6, 0, 1, 0);
        step(0, 4'h0, 1, 1, 0);
        chk("fl_data",    32'(out_data),    32'h0065);
        chk("fl_data_m",  32'(out_data_m),  32'h5600);
        chk("fl_partial", 32'(out_partial), 32'h1);
        step(0, 4'h0, 0, 1, 0);
        step(0, 4'h0, 1, 1, 0);
        chk("fl_empty", 32'(out_valid), 32'h0);
        step(1, 4'h1, 0, 1, 0);
        step(1, 4'h2, 0, 1, 0);
        step(1, 4'h3, 0, 1, 0);
        step(1, 4'h4, 1, 1, 0);
        chk("flf_data",    32'(out_data),    32'h4321);
        chk("flf_partial", 32'(out_partial), 32'h0);
        step(0, 4'h0, 0, 1, 0);

        // Async reset mid-word with a held word
        for (int i = 1; i <= 4; i++) step(1, 4'(i), 0, 0, 0);
        step(1, 4'h7, 0, 0, 0);
        step(1, 4'h8, 0, 0, 0);
        chk("pre_rst_fill", 32'(fill), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid",   32'(out_valid),   32'h0);
        chk("arst_data",    32'(out_data),    32'h0);
        chk("arst_fill",    32'(fill),        32'h0);
        chk("arst_ovf",     32'(overflow),    32'h0);
        chk("arst_partial", 32'(out_partial), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) step(1, 4'(i), 0, 1, 0);
        chk("post_rst_data", 32'(out_data), 32'h4321);
        step(0, 4'h0, 0, 1, 0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 60) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
